// File: rtl/ring_freq_pkg.sv
// ring_freq_pkg: shared definitions for the ring oscillator frequency counter.
//   state_e       - measurement sequencer states
//   SYNC_STAGES   - depth of the div_msb synchroniser into clk
//   DRAIN_CYCLES  - clk cycles with the ring stopped before the result is published
//   is_ring_on    - states in which the ring oscillator is enabled
//   is_busy_state - states in which a measurement is in flight
package ring_freq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int SYNC_STAGES  = 2;
  localparam int DRAIN_CYCLES = 3;

  function automatic logic is_ring_on(input state_e s);
    logic on_v;
    case (s)
      ST_WARMUP:  on_v = 1'b1;
      ST_MEASURE: on_v = 1'b1;
      default:    on_v = 1'b0;
    endcase
    return on_v;
  endfunction

  function automatic logic is_busy_state(input state_e s);
    logic busy_v;
    case (s)
      ST_WARMUP:  busy_v = 1'b1;
      ST_MEASURE: busy_v = 1'b1;
      ST_DRAIN:   busy_v = 1'b1;
      default:    busy_v = 1'b0;
    endcase
    return busy_v;
  endfunction

endpackage

// File: rtl/ring_prescaler.sv
// ring_prescaler: divider running in the ring oscillator's own clock domain.
// This is the only logic clocked by ring_out, so the domain can be constrained
// on its own; only div_msb leaves it.
//   ring_out (in)  - raw ring oscillator output, used as a clock
//   rst_n    (in)  - asynchronous active-low clear
//   div_msb  (out) - MSB of the divider: one rising edge per 2^PRESCALE_BITS ring periods
module ring_prescaler #(
  parameter int PRESCALE_BITS = 4
) (
  input  logic ring_out,
  input  logic rst_n,
  output logic div_msb
);

  logic [PRESCALE_BITS-1:0] div_r;

  // Free-running divider; it keeps its phase while the ring is stopped.
  always_ff @(posedge ring_out or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= {PRESCALE_BITS{1'b0}};
    end else begin
      div_r <= div_r + PRESCALE_BITS'(1'b1);
    end
  end

  assign div_msb = div_r[PRESCALE_BITS-1];

endmodule

// File: rtl/ring_osc_freq_counter.sv
// ring_osc_freq_counter: measures the enable-gated ring oscillator frequency.
// The ring is enabled, allowed to settle, then rising edges of the prescaled
// ring signal are counted over a programmable number of clk cycles. The ring is
// then stopped, the synchroniser drains, and the count is published with a
// one-cycle done pulse.
//   clk      (in)  - system clock
//   rst_n    (in)  - asynchronous active-low reset, clears both domains
//   start    (in)  - measurement request, accepted only when idle
//   window   (in)  - gate length in clk cycles, latched on an accepted start
//   ring_out (in)  - raw ring oscillator output, asynchronous to clk
//   ring_en  (out) - registered ring oscillator enable
//   busy     (out) - high from an accepted start until done
//   done     (out) - one-cycle pulse when count is updated
//   count    (out) - last measurement, in prescaled edges (saturating)
//   ovf      (out) - only with RING_FREQ_OVF_EN defined: an edge was lost to saturation
// Optional feature macro: RING_FREQ_OVF_EN.
module ring_osc_freq_counter
  import ring_freq_pkg::*;
#(
  parameter int PRESCALE_BITS = 4,
  parameter int COUNT_W       = 16,
  parameter int WINDOW_W      = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WINDOW_W-1:0] window,
  input  logic                ring_out,
  output logic                ring_en,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  count
`ifdef RING_FREQ_OVF_EN
  ,
  output logic                ovf
`endif
);

  // One shared cycle timer serves warmup, measure and drain; it must also hold
  // the settle and drain lengths when the window input is narrow.
  localparam int TMR_W = (WINDOW_W > 8) ? WINDOW_W : 8;
  localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   DRAIN_LAST  = TMR_W'(DRAIN_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX     = {COUNT_W{1'b1}};

  state_e                   state_r;
  state_e                   state_nxt_s;
  logic [TMR_W-1:0]         timer_r;
  logic                     timer_clr_s;
  logic [TMR_W-1:0]         meas_last_s;
  logic [WINDOW_W-1:0]      window_r;
  logic [COUNT_W-1:0]       edge_cnt_r;
  logic                     accept_s;
  logic                     div_msb_s;
  logic [SYNC_STAGES-1:0]   sync_r;
  logic                     hist_r;
  logic                     rise_s;
  logic                     ring_en_r;
  logic                     busy_r;
  logic                     done_r;
  logic [COUNT_W-1:0]       count_r;

  ring_prescaler #(
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_prescaler (
    .ring_out (ring_out),
    .rst_n    (rst_n),
    .div_msb  (div_msb_s)
  );

  // Bring div_msb into clk and keep one history bit for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], div_msb_s};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise_s      = sync_r[SYNC_STAGES-1] & ~hist_r;
  assign accept_s    = (state_r == ST_IDLE) & start;
  assign meas_last_s = TMR_W'(window_r) - TMR_W'(1'b1);

  // Sequencer next state; the timer restarts on every state change.
  always_comb begin
    state_nxt_s = state_r;
    timer_clr_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        timer_clr_s = 1'b1;
        if (start) begin
          state_nxt_s = ST_WARMUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WARMUP: begin
        if (timer_r == SETTLE_LAST) begin
          timer_clr_s = 1'b1;
          if (window_r != {WINDOW_W{1'b0}}) begin
            state_nxt_s = ST_MEASURE;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end else begin
          state_nxt_s = ST_WARMUP;
        end
      end
      ST_MEASURE: begin
        if (timer_r == meas_last_s) begin
          timer_clr_s = 1'b1;
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_MEASURE;
        end
      end
      ST_DRAIN: begin
        if (timer_r == DRAIN_LAST) begin
          timer_clr_s = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        timer_clr_s = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        timer_clr_s = 1'b1;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and shared cycle timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      timer_r <= {TMR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (timer_clr_s) begin
        timer_r <= {TMR_W{1'b0}};
      end else begin
        timer_r <= timer_r + TMR_W'(1'b1);
      end
    end
  end

  // Window latch and saturating edge counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_r   <= {WINDOW_W{1'b0}};
      edge_cnt_r <= {COUNT_W{1'b0}};
    end else if (accept_s) begin
      window_r   <= window;
      edge_cnt_r <= {COUNT_W{1'b0}};
    end else if ((state_r == ST_MEASURE) && rise_s && (edge_cnt_r != CNT_MAX)) begin
      edge_cnt_r <= edge_cnt_r + COUNT_W'(1'b1);
    end
  end

  // Outputs are decoded from the next state so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_en_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      count_r   <= {COUNT_W{1'b0}};
    end else begin
      ring_en_r <= is_ring_on(state_nxt_s);
      busy_r    <= is_busy_state(state_nxt_s);
      done_r    <= (state_nxt_s == ST_DONE);
      if (state_nxt_s == ST_DONE) begin
        count_r <= edge_cnt_r;
      end
    end
  end

  assign ring_en = ring_en_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign count   = count_r;

`ifdef RING_FREQ_OVF_EN
  logic sat_r;
  logic ovf_r;

  // Remember whether any edge arrived while the counter was already full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_r <= 1'b0;
    end else if (accept_s) begin
      sat_r <= 1'b0;
    end else if ((state_r == ST_MEASURE) && rise_s && (edge_cnt_r == CNT_MAX)) begin
      sat_r <= 1'b1;
    end
  end

  // Overflow flag published together with count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (state_nxt_s == ST_DONE) begin
      ovf_r <= sat_r;
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_ring_osc_freq_counter.sv
// Bench for ring_osc_freq_counter: a 16-bit and an 8-bit counter share all
// inputs. The ring model toggles every 2 time units while enabled (period 4),
// clk has period 20, so one prescaled edge arrives every 3.2 clk cycles.
module tb_ring_osc_freq_counter;

  localparam int SETTLE = 8;
  localparam int DRAIN  = 3;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        start     = 1'b0;
  logic        ring_out  = 1'b0;
  logic        dead_ring = 1'b0;
  logic [15:0] window    = 16'd0;
  logic        ring_en, busy, done;
  logic        ring_en8, busy8, done8;
  logic [15:0] count;
  logic [7:0]  count8;
`ifdef RING_FREQ_OVF_EN
  logic        ovf, ovf8;
`endif

  int n_vec = 0;
  int n_err = 0;
  int prev_lo = 0;
  int prev_hi = 0;

  ring_osc_freq_counter #(.PRESCALE_BITS(4), .COUNT_W(16), .WINDOW_W(16), .SETTLE_CYCLES(SETTLE)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .window(window), .ring_out(ring_out),
    .ring_en(ring_en), .busy(busy), .done(done), .count(count)
`ifdef RING_FREQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  ring_osc_freq_counter #(.PRESCALE_BITS(4), .COUNT_W(8), .WINDOW_W(16), .SETTLE_CYCLES(SETTLE)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .window(window), .ring_out(ring_out),
    .ring_en(ring_en8), .busy(busy8), .done(done8), .count(count8)
`ifdef RING_FREQ_OVF_EN
    , .ovf(ovf8)
`endif
  );

  always #10 clk = ~clk;

  // Enable-gated ring oscillator; edges fall on odd times, clk edges on even times.
  initial begin
    #1;
    forever begin
      #2;
      if (ring_en && !dead_ring) ring_out = ~ring_out;
      else ring_out = 1'b0;
    end
  end

  task automatic check(input string name, input longint act, input longint lo, input longint hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference: prescaled edges in a w-cycle gate are w*20/64 = w*5/16, rounded either way.
  function automatic int edges_lo(input int w, input bit dd);
    return dd ? 0 : (w * 5) / 16;
  endfunction
  function automatic int edges_hi(input int w, input bit dd);
    return dd ? 0 : (w * 5 + 15) / 16;
  endfunction
  function automatic int min255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  typedef struct {
    int w;
    bit dd;
    bit poke;
    int lat;
    int lo;
    int hi;
  } vec_t;

  vec_t tbl[10];

  // One measurement: start during cycle 0, then sample at every negedge of cycles 1..lat+6.
  task automatic run_one(input vec_t v);
    int done_at, ndone, ndone8, ren_first, ren_last, ren_last8;
    done_at = -1; ndone = 0; ndone8 = 0; ren_first = -1; ren_last = -1; ren_last8 = -1;
    dead_ring = v.dd;
    @(negedge clk);
    window = 16'(v.w);
    start  = 1'b1;
    for (int k = 1; k <= v.lat + 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) begin
        window = 16'hFFFF;
        check("busy_after_start", busy, 1, 1);
      end
      if (k == 5) check("count_held", count, prev_lo, prev_hi);
      if (k == v.lat + 1) check("busy_after_done", busy, 0, 0);
      if (ring_en) begin
        if (ren_first < 0) ren_first = k;
        ren_last = k;
      end
      if (ring_en8) ren_last8 = k;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (done8) ndone8++;
      if (v.poke && (k == 20 || k == v.lat)) start = 1'b1;
    end
    start = 1'b0;
    check("done_latency", done_at, v.lat, v.lat);
    check("done_pulses", ndone, 1, 1);
    check("done8_pulses", ndone8, 1, 1);
    check("ring_en_first", ren_first, 1, 1);
    check("ring_en_last", ren_last, v.lat - DRAIN - 1, v.lat - DRAIN - 1);
    check("ring_en8_last", ren_last8, v.lat - DRAIN - 1, v.lat - DRAIN - 1);
    check("count16", count, v.lo, v.hi);
    check("count8", count8, min255(v.lo), min255(v.hi));
`ifdef RING_FREQ_OVF_EN
    check("ovf16", ovf, 0, 0);
    if (v.hi <= 255) check("ovf8", ovf8, 0, 0);
    else if (v.lo > 255) check("ovf8", ovf8, 1, 1);
`endif
    prev_lo = v.lo;
    prev_hi = v.hi;
  endtask

  function automatic vec_t mk(input int w, input bit dd, input bit poke);
    vec_t v;
    v.w = w; v.dd = dd; v.poke = poke;
    v.lat = 1 + SETTLE + w + DRAIN;
    v.lo = edges_lo(w, dd);
    v.hi = edges_hi(w, dd);
    return v;
  endfunction

  initial begin
    tbl[0] = mk(1000, 1'b0, 1'b0);  // nominal
    tbl[1] = mk(1000, 1'b0, 1'b1);  // starts in MEASURE and in DONE ignored
    tbl[2] = mk(0,    1'b0, 1'b0);  // zero window
    tbl[3] = mk(4000, 1'b0, 1'b0);  // 8-bit saturation
    tbl[4] = mk(100,  1'b0, 1'b0);  // 8-bit no saturation
    tbl[5] = mk(500,  1'b1, 1'b0);  // dead ring
    for (int i = 6; i < 10; i++) tbl[i] = mk(int'($urandom_range(1, 700)), 1'b0, 1'b0);

    // Reset state.
    #5;
    check("rst_ring_en", ring_en, 0, 0);
    check("rst_busy", busy, 0, 0);
    check("rst_done", done, 0, 0);
    check("rst_count", count, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_one(tbl[i]);

    // Reset in the middle of MEASURE: outputs clear before the next clk edge.
    dead_ring = 1'b0;
    @(negedge clk);
    window = 16'd1000;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("pre_rst_busy", busy, 1, 1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_ring_en", ring_en, 0, 0);
    check("mid_rst_busy", busy, 0, 0);
    check("mid_rst_done", done, 0, 0);
    check("mid_rst_count", count, 0, 0);
    check("mid_rst_count8", count8, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", busy, 0, 0);
    prev_lo = 0;
    prev_hi = 0;
    run_one(mk(200, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
